reset_out_ctrl: RTL

Receive-side reset controller for the 4-bit 8085-style core. It consumes the board/generator `Rst` line (RESET IN) and produces the core-side sequence: a stretched `rst_out` (RESET OUT) for peripherals, a bus-drain wait, and a one-cycle program-counter vector load. It then enables the core. While the core is running it accepts a handshaked software reset request and, optionally, a watchdog reset, and records the cause of the last reset.

---
 rtl/reset_out_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reset_out_ctrl.sv
// Receive-side reset sequencer: RESET IN -> stretched RESET OUT, bus drain, PC vector load, run.
// Optional watchdog reset is built when the RST_WDT_EN macro is defined.
module reset_out_ctrl #(
    parameter int                HOLD_CYC  = 8,
    parameter int                DRAIN_MAX = 16,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RST_VEC   = '0,
    parameter int                WDT_CYC   = 255
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              bus_idle,
    input  logic              sw_rst_req,
    input  logic              wdt_kick,
    output logic              rst_out,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_vec,
    output logic              core_en,
    output logic              sw_rst_ack,
    output logic [1:0]        rst_cause,
    output logic              drain_to
);

    localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam int DRAIN_W = $clog2(DRAIN_MAX + 1);

    localparam logic [1:0] CAUSE_HARD = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;

    typedef enum logic [2:0] {
        S_ASSERT,
        S_HOLD,
        S_DRAIN,
        S_BOOT,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [1:0]         cause_q, cause_d;
    logic               dto_q, dto_d;
    logic               ack_q, ack_d;

`ifdef RST_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);
    localparam logic [1:0] CAUSE_WDT = 2'b11;
    logic [WDT_W-1:0] wdt_q, wdt_d;
`else
    logic unused_kick;
    assign unused_kick = wdt_kick;
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= S_ASSERT;
            hold_q  <= '0;
            drain_q <= '0;
            cause_q <= CAUSE_HARD;
            dto_q   <= 1'b0;
            ack_q   <= 1'b0;
`ifdef RST_WDT_EN
            wdt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            drain_q <= drain_d;
            cause_q <= cause_d;
            dto_q   <= dto_d;
            ack_q   <= ack_d;
`ifdef RST_WDT_EN
            wdt_q   <= wdt_d;
`endif
        end
    end

    // Counters default to zero so each one restarts cleanly on entry to its state.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        drain_d = '0;
        cause_d = cause_q;
        dto_d   = dto_q;
        ack_d   = 1'b0;
`ifdef RST_WDT_EN
        wdt_d   = '0;
`endif
        case (state_q)
            S_ASSERT: state_d = S_HOLD;
            S_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (bus_idle) begin
                    state_d = S_BOOT;
                end else if (drain_q == DRAIN_W'(DRAIN_MAX - 1)) begin
                    state_d = S_BOOT;
                    dto_d   = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                // Software request outranks a coincident watchdog expiry.
                if (sw_rst_req) begin
                    state_d = S_HOLD;
                    cause_d = CAUSE_SW;
                    ack_d   = 1'b1;
                end
`ifdef RST_WDT_EN
                else if (!wdt_kick && wdt_q == WDT_W'(WDT_CYC - 1)) begin
                    state_d = S_HOLD;
                    cause_d = CAUSE_WDT;
                end else if (!wdt_kick) begin
                    wdt_d = wdt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_ASSERT;
        endcase
    end

    assign rst_out    = (state_q == S_ASSERT) || (state_q == S_HOLD) || (state_q == S_DRAIN);
    assign pc_load    = (state_q == S_BOOT);
    assign core_en    = (state_q == S_RUN);
    assign pc_vec     = RST_VEC;
    assign sw_rst_ack = ack_q;
    assign rst_cause  = cause_q;
    assign drain_to   = dto_q;

endmodule
